// File: rtl/i2c_wb_sequencer.sv
// Wishbone master that turns single-register I2C device requests into the
// TXR/CR/SR/RXR access sequence of an 8-bit I2C master core.
module i2c_wb_sequencer #(
    parameter logic [15:0] PRESCALE   = 16'd99,
    parameter logic [15:0] POLL_LIMIT = 16'd4095,
    parameter logic        ENABLE_IEN = 1'b0
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_rnw_i,
    input  logic [6:0] req_dev_i,
    input  logic [7:0] req_reg_i,
    input  logic [7:0] req_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic [1:0] rsp_err_o,
    output logic       busy_o,
    output logic [2:0] wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    input  logic [7:0] wbm_dat_i,
    output logic       wbm_we_o,
    output logic       wbm_stb_o,
    output logic       wbm_cyc_o,
    input  logic       wbm_ack_i
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_TXR, S_CR, S_POLL, S_STOP, S_RXR
    } state_t;

    state_t      r_state;
    logic [1:0]  r_step;
    logic [15:0] r_cnt;
    logic        r_rnw;
    logic [6:0]  r_dev;
    logic [7:0]  r_reg;
    logic [7:0]  r_wdata;
    logic [1:0]  r_err;
    logic [7:0]  r_rdata;
    logic        r_rsp_valid;
    logic        r_ready;
    logic        r_busy;
    logic [2:0]  r_adr;
    logic [7:0]  r_dat;
    logic        r_we;
    logic        r_cyc;
    logic        r_stb;

    logic [7:0]  w_txr;
    logic [7:0]  w_cr;
    logic [2:0]  w_adr;
    logic [7:0]  w_dat;
    logic        w_we;
    logic [1:0]  w_last;
    logic        w_ackchk;

    // Per-byte TXR/CR pair; the final read byte has no TXR and no ACK check
    always_comb begin
        w_txr    = 8'h00;
        w_cr     = 8'h00;
        w_adr    = 3'd0;
        w_dat    = 8'h00;
        w_we     = 1'b0;
        w_last   = r_rnw ? 2'd3 : 2'd2;
        w_ackchk = !(r_rnw && r_step == 2'd3);
        case (r_step)
            2'd0: begin
                w_txr = {r_dev, 1'b0};
                w_cr  = 8'h90;
            end
            2'd1: begin
                w_txr = r_reg;
                w_cr  = 8'h10;
            end
            2'd2: begin
                w_txr = r_rnw ? {r_dev, 1'b1} : r_wdata;
                w_cr  = r_rnw ? 8'h90 : 8'h50;
            end
            default: w_cr = 8'h68;
        endcase
        case (r_state)
            S_INIT: begin
                w_adr = {1'b0, r_step};
                w_we  = 1'b1;
                if (r_step == 2'd0)
                    w_dat = PRESCALE[7:0];
                else if (r_step == 2'd1)
                    w_dat = PRESCALE[15:8];
                else
                    w_dat = {1'b1, ENABLE_IEN, 6'b0};
            end
            S_TXR: begin
                w_adr = 3'd3;
                w_dat = w_txr;
                w_we  = 1'b1;
            end
            S_CR: begin
                w_adr = 3'd4;
                w_dat = w_cr;
                w_we  = 1'b1;
            end
            S_POLL: w_adr = 3'd4;
            S_STOP: begin
                w_adr = 3'd4;
                w_dat = 8'h40;
                w_we  = 1'b1;
            end
            S_RXR:  w_adr = 3'd3;
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= S_INIT;
            r_step      <= 2'd0;
            r_cnt       <= 16'd0;
            r_rnw       <= 1'b0;
            r_dev       <= 7'd0;
            r_reg       <= 8'h00;
            r_wdata     <= 8'h00;
            r_err       <= 2'd0;
            r_rdata     <= 8'h00;
            r_rsp_valid <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
            r_adr       <= 3'd0;
            r_dat       <= 8'h00;
            r_we        <= 1'b0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (r_state == S_IDLE) begin
                if (req_valid_i && r_ready) begin
                    r_rnw   <= req_rnw_i;
                    r_dev   <= req_dev_i;
                    r_reg   <= req_reg_i;
                    r_wdata <= req_wdata_i;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b1;
                    r_step  <= 2'd0;
                    r_cnt   <= 16'd0;
                    r_state <= S_TXR;
                end
            end else if (!r_cyc) begin
                // Launch only from an idle bus: guarantees a gap after each ack
                r_adr <= w_adr;
                r_dat <= w_dat;
                r_we  <= w_we;
                r_cyc <= 1'b1;
                r_stb <= 1'b1;
            end else if (wbm_ack_i) begin
                r_cyc <= 1'b0;
                r_stb <= 1'b0;
                case (r_state)
                    S_INIT: begin
                        if (r_step == 2'd2) begin
                            r_step  <= 2'd0;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_step <= r_step + 2'd1;
                        end
                    end
                    S_TXR: r_state <= S_CR;
                    S_CR:  r_state <= S_POLL;
                    S_POLL: begin
                        if (wbm_dat_i[5]) begin
                            r_err       <= 2'd2;
                            r_rsp_valid <= 1'b1;
                            r_busy      <= 1'b0;
                            r_ready     <= 1'b1;
                            r_state     <= S_IDLE;
                        end else if (wbm_dat_i[1]) begin
                            if (r_cnt == POLL_LIMIT - 16'd1) begin
                                r_err   <= 2'd3;
                                r_state <= S_STOP;
                            end else begin
                                r_cnt <= r_cnt + 16'd1;
                            end
                        end else if (w_ackchk && wbm_dat_i[7]) begin
                            r_err   <= 2'd1;
                            r_state <= S_STOP;
                        end else if (r_step == w_last) begin
                            if (r_rnw) begin
                                r_state <= S_RXR;
                            end else begin
                                r_err       <= 2'd0;
                                r_rsp_valid <= 1'b1;
                                r_busy      <= 1'b0;
                                r_ready     <= 1'b1;
                                r_state     <= S_IDLE;
                            end
                        end else begin
                            r_step  <= r_step + 2'd1;
                            r_cnt   <= 16'd0;
                            r_state <= (r_rnw && r_step == 2'd2) ? S_CR : S_TXR;
                        end
                    end
                    S_STOP: begin
                        r_rsp_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_ready     <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                    S_RXR: begin
                        r_rdata     <= wbm_dat_i;
                        r_err       <= 2'd0;
                        r_rsp_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_ready     <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign req_ready_o = r_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;
    assign busy_o      = r_busy;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign wbm_we_o    = r_we;
    assign wbm_stb_o   = r_stb;
    assign wbm_cyc_o   = r_cyc;

endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// Bench for i2c_wb_sequencer: behavioural I2C core model on the Wishbone side
// and a transaction-level reference of the expected access sequence.
module tb_i2c_wb_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rnw = 1'b0;
    logic [6:0] req_dev = 7'd0;
    logic [7:0] req_reg = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic       busy;
    logic [2:0] wbm_adr;
    logic [7:0] wbm_dat_o;
    logic [7:0] wbm_dat_i = 8'h00;
    logic       wbm_we;
    logic       wbm_stb;
    logic       wbm_cyc;
    logic       wbm_ack = 1'b0;

    always #5 clk = ~clk;

    i2c_wb_sequencer #(
        .PRESCALE   (16'd99),
        .POLL_LIMIT (16'd8),
        .ENABLE_IEN (1'b0)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_rnw_i   (req_rnw),
        .req_dev_i   (req_dev),
        .req_reg_i   (req_reg),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy),
        .wbm_adr_o   (wbm_adr),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_we_o    (wbm_we),
        .wbm_stb_o   (wbm_stb),
        .wbm_cyc_o   (wbm_cyc),
        .wbm_ack_i   (wbm_ack)
    );

    int errors = 0;
    int checks = 0;

    // Core model state
    logic [10:0] wlog[$];
    int          polls = 0;
    int          rxr_reads = 0;
    int          byte_idx = -1;
    int          tip_left = 0;
    int          m_tip = 0;
    int          m_fault = 0;
    int          m_fb = -1;
    logic [7:0]  m_rxr = 8'h00;
    int          wait_cnt = 0;
    int          lat = 0;
    int          n_rsp = 0;
    logic [7:0]  exp_rdata = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural I2C core: random ack latency, TIP for m_tip polls per byte,
    // then the fault selected for byte m_fb (1 NACK, 2 AL, 3 stuck TIP).
    always @(negedge clk) begin
        if (rsp_valid) n_rsp++;
        if (wbm_ack) begin
            wbm_ack = 1'b0;
            chk("bus_gap", {30'd0, wbm_stb, wbm_cyc}, 32'd0);
        end else if (wbm_stb) begin
            if (wait_cnt < lat) begin
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                lat = $urandom_range(0, 2);
                chk("cyc_with_stb", {31'd0, wbm_cyc}, 32'd1);
                wbm_ack = 1'b1;
                wbm_dat_i = 8'h00;
                if (wbm_we) begin
                    wlog.push_back({wbm_adr, wbm_dat_o});
                    if (wbm_adr == 3'd4 && wbm_dat_o != 8'h40) begin
                        byte_idx++;
                        tip_left = m_tip;
                    end
                end else if (wbm_adr == 3'd4) begin
                    polls++;
                    if (byte_idx == m_fb && m_fault == 3) wbm_dat_i = 8'h02;
                    else if (tip_left > 0) begin
                        tip_left--;
                        wbm_dat_i = 8'h02;
                    end
                    else if (byte_idx == m_fb && m_fault == 1) wbm_dat_i = 8'h80;
                    else if (byte_idx == m_fb && m_fault == 2) wbm_dat_i = 8'h20;
                end else if (wbm_adr == 3'd3) begin
                    rxr_reads++;
                    wbm_dat_i = m_rxr;
                end
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic cmp_log(input string tag, input logic [10:0] eq[$]);
        int n;
        chk({tag, "_len"}, wlog.size(), eq.size());
        n = (wlog.size() < eq.size()) ? wlog.size() : eq.size();
        for (int i = 0; i < n; i++)
            chk({tag, "_entry"}, {21'd0, wlog[i]}, {21'd0, eq[i]});
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (!req_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run_txn(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input logic [7:0] rx, input int tip,
                           input int fault, input int fb);
        logic [10:0] eq[$];
        logic [7:0]  txr[4];
        logic [7:0]  cr[4];
        int          nb;
        int          ep;
        int          er;
        int          stopped;
        int          k;
        // Reference: expected access list from the byte-step rules
        txr[0] = {dev, 1'b0}; cr[0] = 8'h90;
        txr[1] = rg;          cr[1] = 8'h10;
        txr[2] = rnw ? {dev, 1'b1} : wd;
        cr[2]  = rnw ? 8'h90 : 8'h50;
        txr[3] = 8'h00;       cr[3] = 8'h68;
        nb = rnw ? 4 : 3;
        ep = 0;
        er = 0;
        stopped = 0;
        for (int i = 0; i < nb && stopped == 0; i++) begin
            if (i != 3) eq.push_back({3'd3, txr[i]});
            eq.push_back({3'd4, cr[i]});
            if (i == fb && fault == 3) begin
                ep += 8;
                eq.push_back({3'd4, 8'h40});
                er = 3;
                stopped = 1;
            end else begin
                ep += tip + 1;
                if (i == fb && fault == 2) begin
                    er = 2;
                    stopped = 1;
                end else if (i == fb && fault == 1 && i != 3) begin
                    eq.push_back({3'd4, 8'h40});
                    er = 1;
                    stopped = 1;
                end
            end
        end
        if (rnw && stopped == 0) exp_rdata = rx;

        wait_ready("txn");
        wlog.delete();
        polls = 0;
        rxr_reads = 0;
        byte_idx = -1;
        m_tip = tip;
        m_fault = fault;
        m_fb = fb;
        m_rxr = rx;
        req_rnw = rnw;
        req_dev = dev;
        req_reg = rg;
        req_wdata = wd;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_after_accept", {30'd0, busy, req_ready}, 32'd2);
        k = 0;
        while (!rsp_valid && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_err", {30'd0, rsp_err}, er);
        chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_rdata});
        chk("busy_at_rsp", {31'd0, busy}, 32'd0);
        cmp_log("wlog", eq);
        chk("sr_polls", polls, ep);
        chk("rxr_reads", rxr_reads, (rnw && stopped == 0) ? 1 : 0);
        @(negedge clk);
        chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [10:0] init_q[$];
        int          k;
        int          nr;
        init_q.push_back({3'd0, 8'h63});
        init_q.push_back({3'd1, 8'h00});
        init_q.push_back({3'd2, 8'h80});

        repeat (3) @(negedge clk);
        chk("rst_wbm", {18'd0, wbm_adr, wbm_dat_o, wbm_we, wbm_stb, wbm_cyc}, 32'd0);
        chk("rst_ctl", {29'd0, req_ready, busy, rsp_valid}, 32'd2);
        chk("rst_rsp", {22'd0, rsp_rdata, rsp_err}, 32'd0);
        wlog.delete();
        rst = 1'b0;
        wait_ready("init");
        cmp_log("init", init_q);

        run_txn(1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, 3, 0, -1);
        run_txn(1'b1, 7'h50, 8'h34, 8'h00, 8'h5C, 3, 0, -1);
        run_txn(1'b0, 7'h50, 8'h56, 8'h11, 8'h00, 1, 1, 0);
        run_txn(1'b1, 7'h21, 8'h9A, 8'h00, 8'h77, 2, 2, 1);
        run_txn(1'b0, 7'h33, 8'h01, 8'h02, 8'h00, 0, 3, 2);
        run_txn(1'b1, 7'h7F, 8'hFF, 8'h00, 8'hC3, 1, 1, 3);
        run_txn(1'b1, 7'h01, 8'h80, 8'h00, 8'h3E, 7, 0, -1);
        run_txn(1'b0, 7'h00, 8'h00, 8'hFF, 8'h00, 0, 0, -1);

        for (int t = 0; t < 30; t++) begin
            int f;
            f = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            run_txn(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), $urandom_range(0, 7), f, $urandom_range(0, 3));
        end

        // Reset in the middle of a read while the bus strobe is high
        wait_ready("pre_rst");
        byte_idx = -1;
        polls = 0;
        m_tip = 2;
        m_fault = 0;
        m_fb = -1;
        req_rnw = 1'b1;
        req_dev = 7'h50;
        req_reg = 8'h44;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!(polls >= 4 && wbm_stb) && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("mid_read_stb", {31'd0, wbm_stb}, 32'd1);
        nr = n_rsp;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_drop_bus", {30'd0, wbm_stb, wbm_cyc}, 32'd0);
        chk("rst_busy", {30'd0, busy, req_ready}, 32'd2);
        wlog.delete();
        rst = 1'b0;
        exp_rdata = 8'h00;
        wait_ready("reinit");
        cmp_log("reinit", init_q);
        @(negedge clk);
        chk("no_rsp_on_rst", n_rsp, nr);
        run_txn(1'b1, 7'h50, 8'h34, 8'h00, 8'hA9, 1, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
